// File: rtl/accum_sched_pkg.sv
// Shared types and parameter defaults for the row-accumulation scheduler.
package accum_sched_pkg;

    localparam int DW_DEFAULT      = 24;
    localparam int ADD_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_INFLIGHT,
        SLOT_RESIDENT
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_REDUCE,
        ST_OUTPUT
    } fsm_state_e;

endpackage

// File: rtl/accum_tag_pipe.sv
// Shift register that follows each adder issue; its exit lines up with the
// matching adder result, naming the slot that result belongs to.
module accum_tag_pipe
    import accum_sched_pkg::*;
#(
    parameter int ADD_LAT = ADD_LAT_DEFAULT,
    parameter int SW      = $clog2(ADD_LAT)
) (
    input  logic          i_clock,
    input  logic          i_clr_n,
    input  logic          i_valid,
    input  logic [SW-1:0] i_slot,
    output logic          o_valid,
    output logic [SW-1:0] o_slot
);

    logic [ADD_LAT-1:0] r_valid;
    logic [SW-1:0]      r_slot [ADD_LAT];

    // Slot indices need no clear: they are only looked at when the valid bit is set.
    always_ff @(posedge i_clock) begin
        if (!i_clr_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[ADD_LAT-2:0], i_valid};
        end
        r_slot[0] <= i_slot;
        for (int s = 1; s < ADD_LAT; s++) begin
            r_slot[s] <= r_slot[s-1];
        end
    end

    assign o_valid = r_valid[ADD_LAT-1];
    assign o_slot  = r_slot[ADD_LAT-1];

endmodule

// File: rtl/accum_row_sched.sv
// Shares one pipelined adder among ADD_LAT partial-sum slots of a row, then
// folds the slots pairwise and hands out one row sum per row.
module accum_row_sched
    import accum_sched_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int ADD_LAT = ADD_LAT_DEFAULT
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    input  logic          i_in_last,
    output logic          o_add_valid,
    output logic [DW-1:0] o_add_a,
    output logic [DW-1:0] o_add_b,
    input  logic [DW-1:0] i_sum_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data
);

    localparam int SW = $clog2(ADD_LAT);

    fsm_state_e  r_state;
    fsm_state_e  w_state_next;
    slot_state_e r_slot_st      [ADD_LAT];
    slot_state_e w_slot_st_next [ADD_LAT];
    logic [DW-1:0] r_partial [ADD_LAT];
    logic [DW-1:0] r_out_data;

    logic          w_ret_valid;
    logic [SW-1:0] w_ret_slot;
    logic [SW-1:0] w_issue_slot;
    logic          w_latch;
    logic          w_reduce_act;

    logic [ADD_LAT-1:0] w_ret_hit;
    logic [ADD_LAT-1:0] w_eff_res;
    logic [ADD_LAT-1:0] w_eff_inf;
    logic [ADD_LAT-1:0] w_eff_free;
    logic [DW-1:0]      w_val [ADD_LAT];

    logic          w_res_lo_ok;
    logic          w_res_hi_ok;
    logic          w_free_ok;
    logic [SW-1:0] w_res_lo;
    logic [SW-1:0] w_res_hi;
    logic [SW-1:0] w_free_lo;

    accum_tag_pipe #(
        .ADD_LAT (ADD_LAT),
        .SW      (SW)
    ) u_tag_pipe (
        .i_clock (i_clock),
        .i_clr_n (i_reset_n),
        .i_valid (o_add_valid),
        .i_slot  (w_issue_slot),
        .o_valid (w_ret_valid),
        .o_slot  (w_ret_slot)
    );

    // Effective slot view: a returning result counts as resident this very
    // cycle, so it can be reused without first parking in r_partial.
    genvar gi;
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_slot
            assign w_ret_hit[gi]  = w_ret_valid && (w_ret_slot == SW'(gi));
            assign w_eff_res[gi]  = (r_slot_st[gi] == SLOT_RESIDENT) || w_ret_hit[gi];
            assign w_eff_inf[gi]  = (r_slot_st[gi] == SLOT_INFLIGHT) && !w_ret_hit[gi];
            assign w_eff_free[gi] = (r_slot_st[gi] == SLOT_FREE);
            assign w_val[gi]      = w_ret_hit[gi] ? i_sum_data : r_partial[gi];
        end
    endgenerate

    always_comb begin
        w_res_lo_ok = 1'b0;
        w_res_hi_ok = 1'b0;
        w_free_ok   = 1'b0;
        w_res_lo    = '0;
        w_res_hi    = '0;
        w_free_lo   = '0;
        for (int s = 0; s < ADD_LAT; s++) begin
            if (w_eff_res[s]) begin
                if (!w_res_lo_ok) begin
                    w_res_lo    = SW'(s);
                    w_res_lo_ok = 1'b1;
                end else if (!w_res_hi_ok) begin
                    w_res_hi    = SW'(s);
                    w_res_hi_ok = 1'b1;
                end
            end
            if (w_eff_free[s] && !w_free_ok) begin
                w_free_lo = SW'(s);
                w_free_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        for (int s = 0; s < ADD_LAT; s++) begin
            w_slot_st_next[s] = w_ret_hit[s] ? SLOT_RESIDENT : r_slot_st[s];
        end
        o_in_ready   = 1'b0;
        o_add_valid  = 1'b0;
        o_add_a      = '0;
        o_add_b      = '0;
        w_issue_slot = '0;
        w_latch      = 1'b0;
        w_reduce_act = 1'b0;

        case (r_state)
            ST_ACCUM: begin
                o_in_ready = (|w_eff_res) || (|w_eff_free);
                if (i_in_valid && o_in_ready) begin
                    o_add_valid = 1'b1;
                    o_add_a     = i_in_data;
                    if (w_ret_valid) begin
                        w_issue_slot = w_ret_slot;
                        o_add_b      = i_sum_data;
                    end else if (w_res_lo_ok) begin
                        w_issue_slot = w_res_lo;
                        o_add_b      = r_partial[w_res_lo];
                    end else begin
                        w_issue_slot = w_free_lo;
                    end
                    w_slot_st_next[w_issue_slot] = SLOT_INFLIGHT;
                    if (i_in_last) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last return can already be folded or latched in its own cycle.
                if (!(|w_eff_inf)) begin
                    w_reduce_act = 1'b1;
                    w_state_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                w_reduce_act = 1'b1;
            end
            ST_OUTPUT: begin
                if (i_out_ready) begin
                    for (int s = 0; s < ADD_LAT; s++) begin
                        w_slot_st_next[s] = SLOT_FREE;
                    end
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase

        if (w_reduce_act) begin
            if (w_res_hi_ok) begin
                o_add_valid  = 1'b1;
                o_add_a      = w_val[w_res_lo];
                o_add_b      = w_val[w_res_hi];
                w_issue_slot = w_res_lo;
                w_slot_st_next[w_res_lo] = SLOT_INFLIGHT;
                w_slot_st_next[w_res_hi] = SLOT_FREE;
            end else if (w_res_lo_ok && !(|w_eff_inf)) begin
                w_latch      = 1'b1;
                w_state_next = ST_OUTPUT;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_ACCUM;
            r_out_data <= '0;
            for (int s = 0; s < ADD_LAT; s++) begin
                r_slot_st[s] <= SLOT_FREE;
            end
        end else begin
            r_state <= w_state_next;
            for (int s = 0; s < ADD_LAT; s++) begin
                r_slot_st[s] <= w_slot_st_next[s];
            end
            if (w_latch) begin
                r_out_data <= w_val[w_res_lo];
            end
        end
    end

    // Contents only matter while a slot is resident, so no reset here.
    always_ff @(posedge i_clock) begin
        if (w_ret_valid) begin
            r_partial[w_ret_slot] <= i_sum_data;
        end
    end

    assign o_out_valid = (r_state == ST_OUTPUT);
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_accum_row_sched.sv
// Bench for accum_row_sched: integer adder stand-in, directed scenarios and
// random rows checked against plain row sums.
module tb_accum_row_sched;

    localparam int DW = 24;
    localparam int AL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          tb_out_ready = 1'b1;
    logic          rand_ready = 1'b1;
    logic          bp_en = 1'b0;
    logic          out_ready;
    logic          in_ready;
    logic          add_valid;
    logic [DW-1:0] add_a;
    logic [DW-1:0] add_b;
    logic [DW-1:0] sum_data;
    logic          out_valid;
    logic [DW-1:0] out_data;

    logic [DW-1:0] add_pipe [AL];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            stalls = 0;
    int            row_vals [16];
    logic [DW-1:0] row_b [16];
    int            row_cyc [16];
    logic [DW-1:0] out_q [$];
    logic [DW-1:0] exp_q [$];

    assign out_ready = bp_en ? rand_ready : tb_out_ready;

    accum_row_sched #(
        .DW      (DW),
        .ADD_LAT (AL)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_add_valid (add_valid),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_sum_data  (sum_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External integer adder: result appears AL cycles after issue; idle slots carry junk.
    always @(posedge clk) begin
        add_pipe[0] <= add_valid ? (add_a + add_b) : DW'($urandom);
        for (int k = 1; k < AL; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign sum_data = add_pipe[AL-1];

    always @(negedge clk) begin
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    always @(posedge clk) begin
        #1;
        rand_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Entered and left just after a rising edge; one line per accepted element.
    task automatic send_row(input int n, input bit gaps, input bit with_last);
        int tries;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = DW'(row_vals[i]);
            in_last  = with_last && (i == n - 1);
            tries = 0;
            @(negedge clk);
            while (!in_ready && tries < 300) begin
                tries++;
                stalls++;
                @(negedge clk);
            end
            check("in_ready_accept", {31'd0, in_ready}, 32'd1);
            check("add_valid_accept", {31'd0, add_valid}, 32'd1);
            check("add_a_accept", {8'd0, add_a}, {8'd0, in_data});
            row_b[i]   = add_b;
            row_cyc[i] = cyc;
            $display("elem cyc=%0d data=%0d last=%0b a=%0d b=%0d", cyc, in_data, in_last, add_a, add_b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_outs(input int n, input string tag);
        int k = 0;
        while (out_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, out_q.size(), n);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] s;
        int n;
        bit g;

        // 1: reset values, and an in-flight preload before reset yields nothing
        do_reset(3);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_add_valid", {31'd0, add_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {8'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        row_vals[0] = 100; row_vals[1] = 200;
        send_row(2, 1'b0, 1'b0);
        do_reset(3);
        repeat (8) begin
            @(negedge clk);
            check("preload_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // 2: single-element row, latency AL+1
        row_vals[0] = 5;
        send_row(1, 1'b0, 1'b1);
        check("single_b", {8'd0, row_b[0]}, 32'd0);
        for (int k = 1; k <= AL + 1; k++) begin
            @(negedge clk);
            check("single_out_valid", {31'd0, out_valid}, (k == AL + 1) ? 32'd1 : 32'd0);
        end
        check("single_out_data", {8'd0, out_data}, 32'd5);
        $display("row single out=%0d", out_data);
        @(negedge clk);
        check("single_after_in_ready", {31'd0, in_ready}, 32'd1);
        check("single_q", out_q.size(), 1);
        out_q.delete();
        @(posedge clk); #1;

        // 3: row 1..8 back-to-back, bypass on the second pass
        for (int i = 0; i < 8; i++) row_vals[i] = i + 1;
        send_row(8, 1'b0, 1'b1);
        check("seq_stalls", stalls, 0);
        check("seq_span", row_cyc[7] - row_cyc[0], 7);
        for (int i = 0; i < 8; i++)
            check("seq_b", {8'd0, row_b[i]}, (i < AL) ? 32'd0 : 32'(row_vals[i-AL]));
        wait_outs(1, "seq_count");
        if (out_q.size() > 0) check("seq_sum", {8'd0, out_q[0]}, 32'd36);
        $display("row 1..8 outputs=%0d", out_q.size());
        out_q.delete();
        @(posedge clk); #1;

        // 4: output backpressure on [7,9]
        tb_out_ready = 1'b0;
        row_vals[0] = 7; row_vals[1] = 9;
        send_row(2, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {8'd0, out_data}, 32'd16);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        tb_out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_q", out_q.size(), 1);
        if (out_q.size() > 0) check("bp_sum", {8'd0, out_q[0]}, 32'd16);
        $display("row [7,9] out=%0d", out_data);
        out_q.delete();
        @(posedge clk); #1;

        // 5: back-to-back rows with gaps
        row_vals[0] = 1; row_vals[1] = 2; row_vals[2] = 3;
        send_row(3, 1'b1, 1'b1);
        row_vals[0] = 10; row_vals[1] = 20;
        send_row(2, 1'b1, 1'b1);
        wait_outs(2, "b2b_count");
        if (out_q.size() > 1) begin
            check("b2b_first", {8'd0, out_q[0]}, 32'd6);
            check("b2b_second", {8'd0, out_q[1]}, 32'd30);
        end
        $display("rows [1,2,3],[10,20] outputs=%0d", out_q.size());
        out_q.delete();
        @(posedge clk); #1;

        // 6: reset with two adds in flight, then row [3]
        row_vals[0] = 4; row_vals[1] = 4; row_vals[2] = 4;
        send_row(3, 1'b0, 1'b0);
        @(posedge clk); #1;
        do_reset(1);
        row_vals[0] = 3;
        send_row(1, 1'b0, 1'b1);
        check("midrst_b", {8'd0, row_b[0]}, 32'd0);
        wait_outs(1, "midrst_count");
        repeat (20) @(negedge clk);
        check("midrst_q", out_q.size(), 1);
        if (out_q.size() > 0) check("midrst_sum", {8'd0, out_q[0]}, 32'd3);
        $display("mid-row reset out count=%0d", out_q.size());
        out_q.delete();
        @(posedge clk); #1;

        // random rows, random gaps and consumer backpressure
        bp_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            g = 1'($urandom_range(0, 1));
            s = '0;
            for (int i = 0; i < n; i++) begin
                row_vals[i] = int'($urandom_range(0, (1 << DW) - 1));
                s = s + DW'(row_vals[i]);
            end
            exp_q.push_back(s);
            send_row(n, g, 1'b1);
        end
        wait_outs(6, "rand_count");
        for (int r = 0; r < 6; r++) begin
            if (r < out_q.size()) begin
                check("rand_sum", {8'd0, out_q[r]}, {8'd0, exp_q[r]});
                $display("rand row %0d out=%0d exp=%0d", r, out_q[r], exp_q[r]);
            end
        end
        bp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
